zstr_rx: RTL and testbench

- Synthesizable receiving end of the z stream (valid/ready) protocol. It is the RTL counterpart that sits where the bench drain sits.
- It accepts transfers from a z stream source into a QL-deep queue.
- It presents the queued words to local logic through a show-ahead pop interface.
- It provides back-pressure to the source through z_rdy.

---
 rtl/zstr_rx.sv | 131 +++++++++++++
 tb/tb_zstr_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/zstr_rx.sv
// zstr_rx: receiving end of a z stream (valid/ready) link.
// Accepted words go into a QL-deep circular queue. Local logic reads the
// queue through a show-ahead pop interface. z_rdy is a registered copy of
// "queue not full", so a pop never frees a slot in the same cycle.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active low
//   z_vld  in   z stream transfer valid
//   z_bus  in   z stream data word (BW)
//   z_rdy  out  z stream transfer ready (registered)
//   r_req  in   pop request; ignored while r_vld=0
//   r_vld  out  queue not empty
//   r_dat  out  head word, or XZ while empty
//   r_cnt  out  number of stored words, 0..QL
//   z_err  out  sticky input-protocol error flag
//
// Build option: define ZSTR_RX_CHK_EN to include the input-side protocol
// checker. The checker flags a valid that is retracted, or data that changes,
// while the source is stalled. When the macro is undefined, z_err is tied to 0.
module zstr_rx #(
  parameter int            BW = 8,
  parameter logic [BW-1:0] XZ = 'x,
  parameter int            QL = 4,
  parameter int            QW = $clog2(QL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          z_vld,
  input  logic [BW-1:0] z_bus,
  output logic          z_rdy,
  input  logic          r_req,
  output logic          r_vld,
  output logic [BW-1:0] r_dat,
  output logic [QW:0]   r_cnt,
  output logic          z_err
);

  localparam logic [QW-1:0] LAST = QW'(QL - 1);
  localparam logic [QW:0]   FULL = (QW + 1)'(QL);

  logic [BW-1:0] mem_q [QL];
  logic [BW-1:0] mem_d [QL];
  logic [QW-1:0] wr_ptr_q, wr_ptr_d;
  logic [QW-1:0] rd_ptr_q, rd_ptr_d;
  logic [QW:0]   cnt_q, cnt_d;
  logic          z_rdy_q, z_rdy_d;
  logic          push, pop;

  always_comb begin
    push     = z_vld && z_rdy_q;
    pop      = r_req && (cnt_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < QL; i++) mem_d[i] = mem_q[i];

    // The pointers wrap explicitly, so a QL that is not a power of two
    // never reaches an unused slot.
    if (push) begin
      mem_d[wr_ptr_q] = z_bus;
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + QW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + QW'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (QW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (QW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // Ready follows the next count, so z_rdy always equals (r_cnt != QL)
    // out of reset, and nothing combinational reaches it.
    z_rdy_d = (cnt_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      z_rdy_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      z_rdy_q  <= z_rdy_d;
    end
  end

  // Storage needs no reset: a word is never shown unless the count covers it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QL; i++) mem_q[i] <= mem_d[i];
  end

  assign z_rdy = z_rdy_q;
  assign r_vld = (cnt_q != '0);
  assign r_dat = r_vld ? mem_q[rd_ptr_q] : XZ;
  assign r_cnt = cnt_q;

`ifdef ZSTR_RX_CHK_EN
  logic          stall_q, stall_d;
  logic [BW-1:0] bus_q, bus_d;
  logic          err_q, err_d;

  always_comb begin
    stall_d = z_vld && !z_rdy_q;
    bus_d   = z_bus;
    err_d   = err_q | (stall_q && (!z_vld || (z_bus != bus_q)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 1'b0;
      bus_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      bus_q   <= bus_d;
      err_q   <= err_d;
    end
  end

  assign z_err = err_q;
`else
  assign z_err = 1'b0;
`endif

endmodule

// File: tb/tb_zstr_rx.sv
module tb_zstr_rx;

  localparam logic [7:0] XZ4 = 8'hE7;
  localparam logic [7:0] XZ3 = 8'h3C;
`ifdef ZSTR_RX_CHK_EN
  localparam logic CHK_EXP = 1'b1;
`else
  localparam logic CHK_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       z_vld4, r_req4, z_rdy4, r_vld4, z_err4;
  logic [7:0] z_bus4, r_dat4;
  logic [2:0] r_cnt4;
  logic       z_vld3, r_req3, z_rdy3, r_vld3, z_err3;
  logic [7:0] z_bus3, r_dat3;
  logic [2:0] r_cnt3;

  int total = 0;
  int bad   = 0;

  zstr_rx #(.BW(8), .XZ(XZ4), .QL(4)) u_dut4 (
    .clk(clk), .rst(rst), .z_vld(z_vld4), .z_bus(z_bus4), .z_rdy(z_rdy4),
    .r_req(r_req4), .r_vld(r_vld4), .r_dat(r_dat4), .r_cnt(r_cnt4), .z_err(z_err4)
  );

  zstr_rx #(.BW(8), .XZ(XZ3), .QL(3)) u_dut3 (
    .clk(clk), .rst(rst), .z_vld(z_vld3), .z_bus(z_bus3), .z_rdy(z_rdy3),
    .r_req(r_req3), .r_vld(r_vld3), .r_dat(r_dat3), .r_cnt(r_cnt3), .z_err(z_err3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    rst = 1'b0;
    #3;
    total++; if (z_rdy4 !== 1'b0) begin bad++; $display("FAIL por_z_rdy got=%0b exp=0", z_rdy4); end
    total++; if (r_dat4 !== XZ4) begin bad++; $display("FAIL por_r_dat got=%h exp=%h", r_dat4, XZ4); end
    #9 rst = 1'b1;
    tick();
    total++; if (z_rdy4 !== 1'b1) begin bad++; $display("FAIL rel_z_rdy got=%0b exp=1", z_rdy4); end
    z_vld4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      z_bus4 = b;
      tick();
    end
    total++; if (r_cnt4 !== 3'd3) begin bad++; $display("FAIL pre_rst_cnt got=%0d exp=3", r_cnt4); end
    #2 rst = 1'b0;
    #1;
    total++; if (z_rdy4 !== 1'b0) begin bad++; $display("FAIL mid_rst_z_rdy got=%0b exp=0", z_rdy4); end
    total++; if (r_vld4 !== 1'b0) begin bad++; $display("FAIL mid_rst_r_vld got=%0b exp=0", r_vld4); end
    total++; if (r_cnt4 !== 3'd0) begin bad++; $display("FAIL mid_rst_r_cnt got=%0d exp=0", r_cnt4); end
    total++; if (r_dat4 !== XZ4) begin bad++; $display("FAIL mid_rst_r_dat got=%h exp=%h", r_dat4, XZ4); end
    total++; if (z_err4 !== 1'b0) begin bad++; $display("FAIL mid_rst_z_err got=%0b exp=0", z_err4); end
    #1;
    z_vld4 = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (z_rdy4 !== 1'b1) begin bad++; $display("FAIL post_rst_z_rdy got=%0b exp=1", z_rdy4); end
    total++; if (r_cnt4 !== 3'd0) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=0", r_cnt4); end
  endtask

  task automatic test_fill();
    logic [7:0] w [4];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    z_vld4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      z_bus4 = w[i];
      tick();
    end
    total++; if (r_cnt4 !== 3'd4) begin bad++; $display("FAIL fill_cnt got=%0d exp=4", r_cnt4); end
    total++; if (z_rdy4 !== 1'b0) begin bad++; $display("FAIL fill_z_rdy got=%0b exp=0", z_rdy4); end
    total++; if (r_dat4 !== 8'h11) begin bad++; $display("FAIL fill_head got=%h exp=11", r_dat4); end
    total++; if (z_err4 !== 1'b0) begin bad++; $display("FAIL fill_z_err got=%0b exp=0", z_err4); end
    z_bus4 = 8'hA5;
    tick();
    tick();
    total++; if (r_cnt4 !== 3'd4) begin bad++; $display("FAIL stall_cnt got=%0d exp=4", r_cnt4); end
    total++; if (r_dat4 !== 8'h11) begin bad++; $display("FAIL stall_head got=%h exp=11", r_dat4); end
    total++; if (z_err4 !== 1'b0) begin bad++; $display("FAIL stall_hold_z_err got=%0b exp=0", z_err4); end
  endtask

  task automatic test_chk();
    z_bus4 = 8'h5A;
    tick();
    total++; if (z_err4 !== CHK_EXP) begin bad++; $display("FAIL chk_set got=%0b exp=%0b", z_err4, CHK_EXP); end
    z_bus4 = 8'hA5;
    tick();
    tick();
    total++; if (z_err4 !== CHK_EXP) begin bad++; $display("FAIL chk_sticky got=%0b exp=%0b", z_err4, CHK_EXP); end
    total++; if (r_cnt4 !== 3'd4) begin bad++; $display("FAIL chk_cnt got=%0d exp=4", r_cnt4); end
  endtask

  task automatic test_drain();
    logic [7:0] w [4];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    z_vld4 = 1'b0;
    r_req4 = 1'b1;
    total++; if (z_rdy4 !== 1'b0) begin bad++; $display("FAIL drain_start_z_rdy got=%0b exp=0", z_rdy4); end
    for (int i = 0; i < 4; i++) begin
      total++; if (r_dat4 !== w[i]) begin bad++; $display("FAIL drain_word%0d got=%h exp=%h", i, r_dat4, w[i]); end
      tick();
      if (i == 0) begin
        total++; if (z_rdy4 !== 1'b1) begin bad++; $display("FAIL drain_z_rdy got=%0b exp=1", z_rdy4); end
      end
    end
    total++; if (r_vld4 !== 1'b0) begin bad++; $display("FAIL drain_r_vld got=%0b exp=0", r_vld4); end
    total++; if (r_dat4 !== XZ4) begin bad++; $display("FAIL drain_r_dat got=%h exp=%h", r_dat4, XZ4); end
    total++; if (r_cnt4 !== 3'd0) begin bad++; $display("FAIL drain_cnt got=%0d exp=0", r_cnt4); end
    tick();
    total++; if (r_cnt4 !== 3'd0) begin bad++; $display("FAIL empty_pop_cnt got=%0d exp=0", r_cnt4); end
    r_req4 = 1'b0;
  endtask

  task automatic test_simul();
    logic [7:0] q [$];
    logic [7:0] b;
    r_req4 = 1'b1;
    z_vld4 = 1'b1;
    b = 8'($urandom);
    z_bus4 = b;
    q.push_back(b);
    tick();
    total++; if (r_cnt4 !== 3'd1) begin bad++; $display("FAIL simul_empty_cnt got=%0d exp=1", r_cnt4); end
    total++; if (r_dat4 !== q[0]) begin bad++; $display("FAIL simul_empty_head got=%h exp=%h", r_dat4, q[0]); end
    r_req4 = 1'b0;
    b = 8'($urandom);
    z_bus4 = b;
    q.push_back(b);
    tick();
    r_req4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (r_dat4 !== q[0]) begin bad++; $display("FAIL simul_head%0d got=%h exp=%h", i, r_dat4, q[0]); end
      b = 8'($urandom);
      z_bus4 = b;
      tick();
      void'(q.pop_front());
      q.push_back(b);
      total++; if (r_cnt4 !== 3'd2) begin bad++; $display("FAIL simul_cnt%0d got=%0d exp=2", i, r_cnt4); end
    end
    z_vld4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (r_dat4 !== q[0]) begin bad++; $display("FAIL simul_tail%0d got=%h exp=%h", i, r_dat4, q[0]); end
      tick();
      void'(q.pop_front());
    end
    r_req4 = 1'b0;
    total++; if (r_vld4 !== 1'b0) begin bad++; $display("FAIL simul_end_r_vld got=%0b exp=0", r_vld4); end
  endtask

  task automatic test_wrap();
    int q [$];
    int next_w = 0;
    int rx = 0;
    int cyc = 0;
    int max_cnt = 0;
    bit push, pop;
    z_vld3 = 1'b0;
    r_req3 = 1'b0;
    z_bus3 = 8'h00;
    while (rx < 10 && cyc < 500) begin
      total++; if (r_cnt3 !== 3'(q.size())) begin bad++; $display("FAIL wrap_cnt c%0d got=%0d exp=%0d", cyc, r_cnt3, q.size()); end
      total++; if (z_rdy3 !== (q.size() != 3)) begin bad++; $display("FAIL wrap_z_rdy c%0d got=%0b exp=%0b", cyc, z_rdy3, q.size() != 3); end
      if (q.size() != 0) begin
        total++; if (r_dat3 !== 8'(q[0])) begin bad++; $display("FAIL wrap_head c%0d got=%h exp=%h", cyc, r_dat3, 8'(q[0])); end
      end else begin
        total++; if (r_dat3 !== XZ3) begin bad++; $display("FAIL wrap_empty c%0d got=%h exp=%h", cyc, r_dat3, XZ3); end
      end
      if (int'(r_cnt3) > max_cnt) max_cnt = int'(r_cnt3);
      if (!z_vld3) begin
        z_vld3 = (next_w < 10) && ($urandom_range(0, 1) == 1);
        z_bus3 = 8'(next_w);
      end
      r_req3 = ($urandom_range(0, 2) != 0);
      push = z_vld3 && (q.size() != 3);
      pop  = r_req3 && (q.size() != 0);
      tick();
      cyc++;
      if (pop) begin
        void'(q.pop_front());
        rx++;
      end
      if (push) begin
        q.push_back(next_w);
        next_w++;
        z_vld3 = 1'b0;
      end
    end
    z_vld3 = 1'b0;
    r_req3 = 1'b0;
    total++; if (rx != 10) begin bad++; $display("FAIL wrap_received got=%0d exp=10 after %0d cycles", rx, cyc); end
    total++; if (max_cnt > 3) begin bad++; $display("FAIL wrap_max_cnt got=%0d exp<=3", max_cnt); end
    total++; if (r_vld3 !== 1'b0) begin bad++; $display("FAIL wrap_end_r_vld got=%0b exp=0", r_vld3); end
    total++; if (z_err3 !== 1'b0) begin bad++; $display("FAIL wrap_z_err got=%0b exp=0", z_err3); end
  endtask

  task automatic test_err_clear();
    #2 rst = 1'b0;
    #1;
    total++; if (z_err4 !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b exp=0", z_err4); end
    #2 rst = 1'b1;
    tick();
    total++; if (z_rdy4 !== 1'b1) begin bad++; $display("FAIL err_clear_z_rdy got=%0b exp=1", z_rdy4); end
  endtask

  initial begin
    rst = 1'b0;
    z_vld4 = 1'b0; r_req4 = 1'b0; z_bus4 = 8'h00;
    z_vld3 = 1'b0; r_req3 = 1'b0; z_bus3 = 8'h00;
    test_reset();
    test_fill();
    test_chk();
    test_drain();
    test_simul();
    test_wrap();
    test_err_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
